pipe_stage_reg_elastic: RTL and testbench

Parametrised successor to the fixed-field inter-stage pipeline registers. It is an elastic two-entry stage: a main entry plus a skid entry, with valid/ready handshakes on both sides.
- Keeps the existing flush/freeze semantics: flush inserts a bubble, freeze holds state.
- Adds backpressure handling, a separate control field that is zeroed on bubbles, occupancy reporting and a saturating stall counter.
- Placed between any two pipeline stages (ID/EXE, EXE/MEM, MEM/WB) in place of the per-stage hand-written registers.

---
 rtl/pipe_stage_reg_elastic.sv | 129 ++++++++++++
 tb/tb_pipe_stage_reg_elastic.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg_elastic.sv
// Elastic two-entry pipeline stage (main + skid) with valid/ready on both sides,
// flush/freeze control, registered occupancy and a saturating stall counter.
module pipe_stage_reg_elastic #(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 8,
  parameter bit CLEAR_DATA = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  input  logic              stall_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_v, skid_v;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [1:0]        occ_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              main_v_nxt, skid_v_nxt;
  logic [CTRL_W-1:0] main_ctrl_nxt, skid_ctrl_nxt;
  logic [DATA_W-1:0] main_data_nxt, skid_data_nxt;
  logic [1:0]        occ_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              accept, drain;

  // in_ready looks only at registered skid_v, so out_ready never reaches it combinationally
  assign in_ready  = ~skid_v & ~freeze & ~flush;
  assign out_valid = main_v & ~freeze & ~flush;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign occupancy = occ_q;
  assign stall_cnt = cnt_q;

  always_comb begin
    main_v_nxt    = main_v;
    main_ctrl_nxt = main_ctrl;
    main_data_nxt = main_data;
    skid_v_nxt    = skid_v;
    skid_ctrl_nxt = skid_ctrl;
    skid_data_nxt = skid_data;

    if (flush) begin
      main_v_nxt    = 1'b0;
      skid_v_nxt    = 1'b0;
      main_ctrl_nxt = '0;
      skid_ctrl_nxt = '0;
      if (CLEAR_DATA) begin
        main_data_nxt = '0;
        skid_data_nxt = '0;
      end
    end else if (!freeze) begin
      if (!main_v) begin
        // skid is never valid while main is empty, so only main can fill here
        if (accept) begin
          main_v_nxt    = 1'b1;
          main_ctrl_nxt = in_ctrl;
          main_data_nxt = in_data;
        end
      end else if (!skid_v) begin
        if (drain && accept) begin
          main_ctrl_nxt = in_ctrl;
          main_data_nxt = in_data;
        end else if (drain) begin
          main_v_nxt    = 1'b0;
          main_ctrl_nxt = '0;
          if (CLEAR_DATA) main_data_nxt = '0;
        end else if (accept) begin
          skid_v_nxt    = 1'b1;
          skid_ctrl_nxt = in_ctrl;
          skid_data_nxt = in_data;
        end
      end else if (drain) begin
        main_ctrl_nxt = skid_ctrl;
        main_data_nxt = skid_data;
        skid_v_nxt    = 1'b0;
        skid_ctrl_nxt = '0;
        if (CLEAR_DATA) skid_data_nxt = '0;
      end
    end

    occ_nxt = {1'b0, main_v_nxt} + {1'b0, skid_v_nxt};

    // clear beats increment; counter sticks at all-ones
    cnt_nxt = cnt_q;
    if (stall_clr)
      cnt_nxt = '0;
    else if (main_v && !out_ready && !freeze && !flush && (cnt_q != {CNT_W{1'b1}}))
      cnt_nxt = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      main_ctrl <= '0;
      skid_ctrl <= '0;
      main_data <= '0;
      skid_data <= '0;
      occ_q     <= '0;
      cnt_q     <= '0;
    end else begin
      main_v    <= main_v_nxt;
      skid_v    <= skid_v_nxt;
      main_ctrl <= main_ctrl_nxt;
      skid_ctrl <= skid_ctrl_nxt;
      main_data <= main_data_nxt;
      skid_data <= skid_data_nxt;
      occ_q     <= occ_nxt;
      cnt_q     <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg_elastic.sv
// Self-checking bench: a depth-2 FIFO scoreboard predicts handshakes, payload
// order, occupancy and the stall counter for directed stimulus.
module tb_pipe_stage_reg_elastic;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0, freeze = 1'b0, stall_clr = 1'b0;
  logic              in_valid = 1'b0, out_ready = 1'b0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready, out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  int errors = 0;
  int checks = 0;

  logic [CTRL_W+DATA_W-1:0] sb[$];
  logic [CNT_W-1:0]         cnt_model = '0;

  pipe_stage_reg_elastic #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA(1'b1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_clr(stall_clr), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one cycle: drive inputs, check outputs against the model mid-cycle, then advance the model
  task automatic applyStimulus(input logic iv, input logic [CTRL_W-1:0] ic,
                               input logic [DATA_W-1:0] id, input logic ordy,
                               input logic fl, input logic fz, input logic clr);
    logic acc, drn;
    in_valid = iv; in_ctrl = ic; in_data = id; out_ready = ordy;
    flush = fl; freeze = fz; stall_clr = clr;
    @(negedge clk);
    checkOutput(fl, fz);
    acc = iv && (sb.size() < 2) && !fz && !fl;
    drn = (sb.size() > 0) && ordy && !fz && !fl;
    if (clr) cnt_model = '0;
    else if ((sb.size() > 0) && !ordy && !fz && !fl && cnt_model != 2'd3) cnt_model++;
    if (fl) sb.delete();
    else begin
      if (drn) void'(sb.pop_front());
      if (acc) sb.push_back({ic, id});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input logic fl, input logic fz);
    logic [CTRL_W+DATA_W-1:0] head;
    head = (sb.size() > 0) ? sb[0] : '0;
    chk("in_ready",  64'(in_ready),  64'((sb.size() < 2) && !fl && !fz));
    chk("out_valid", 64'(out_valid), 64'((sb.size() > 0) && !fl && !fz));
    chk("out_ctrl",  64'(out_ctrl),  64'(head[CTRL_W+DATA_W-1:DATA_W]));
    chk("out_data",  64'(out_data),  64'(head[DATA_W-1:0]));
    chk("occupancy", 64'(occupancy), 64'(sb.size()));
    chk("stall_cnt", 64'(stall_cnt), 64'(cnt_model));
  endtask

  initial begin
    logic [DATA_W-1:0] a, b;

    // reset state
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data",  64'(out_data),  64'(0));
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // streaming 1..4 with out_ready held high
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'(i + 16), 32'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    // backpressure: A then B stall, then drain both
    a = $urandom; b = $urandom;
    applyStimulus(1'b1, 8'hA1, a, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hB2, b, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hC3, 32'hdead_beef, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    // flush with both entries full; item offered during flush is dropped
    applyStimulus(1'b1, 8'h11, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h33, 32'h3333_3333, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

    // freeze for 3 cycles with A in main, then release
    applyStimulus(1'b1, 8'h5A, a, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h6B, b, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h6B, b, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    // saturation: 6 backpressure cycles, then clear together with an increment
    applyStimulus(1'b1, 8'h77, 32'h7777, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_value", 64'(stall_cnt), 64'(3));
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    // async reset between edges with two entries held
    applyStimulus(1'b1, 8'h81, 32'h8181, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h82, 32'h8282, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_occ", 64'(occupancy), 64'(2));
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_out_ctrl",  64'(out_ctrl),  64'(0));
    chk("arst_out_data",  64'(out_data),  64'(0));
    chk("arst_occupancy", 64'(occupancy), 64'(0));
    sb.delete();
    cnt_model = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    applyStimulus(1'b1, 8'h9C, 32'h9999_0001, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
